// File: rtl/gm_cubico_chk.sv
// rtl/gm_cubico_chk.sv - streaming tolerance checker for cubic UFIR filter output against golden-model samples
module gm_cubico_chk #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TOL        = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              ref_valid,
  input  logic [DATA_W-1:0] ref_dpi_1,
  input  logic [DATA_W-1:0] ref_dpi_2,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_y1,
  input  logic [DATA_W-1:0] dut_y2,
  input  logic              clear,
  output logic [CNT_W-1:0]  cmp_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W:0]   max_err,
  output logic              mismatch_pulse,
  output logic              err_flag,
  output logic              ovf_flag,
  output logic              unf_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [DATA_W:0]  TOL_V   = (DATA_W+1)'(TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [OW-1:0]       occ;

  logic                push, pop, empty, full, bypass;
  logic                do_cmp, wr_en, rd_en, ovf_ev, unf_ev, mis_ev;
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0]   cmp_ref1, cmp_ref2;
  logic [DATA_W:0]     abs1, abs2, abs_big, max_next;

  // Signed difference widened by one bit so the magnitude can never wrap.
  function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    return d[DATA_W] ? -d : d;
  endfunction

  // Event decode: clear suppresses every push/pop presented in its cycle.
  always_comb begin
    push     = clk_enable & ref_valid & ~clear;
    pop      = clk_enable & dut_valid & ~clear;
    empty    = (occ == '0);
    full     = (occ == OW'(FIFO_DEPTH));
    bypass   = empty & push & pop;
    do_cmp   = pop & (~empty | push);
    unf_ev   = pop & empty & ~push;
    ovf_ev   = push & full & ~pop;
    wr_en    = push & ~bypass & (~full | pop);
    rd_en    = pop & ~empty;
    head     = mem[rd_ptr];
    cmp_ref1 = empty ? ref_dpi_1 : head[2*DATA_W-1:DATA_W];
    cmp_ref2 = empty ? ref_dpi_2 : head[DATA_W-1:0];
    abs1     = abs_diff(dut_y1, cmp_ref1);
    abs2     = abs_diff(dut_y2, cmp_ref2);
    abs_big  = (abs1 > abs2) ? abs1 : abs2;
    max_next = (abs_big > max_err) ? abs_big : max_err;
    mis_ev   = do_cmp & ((abs1 > TOL_V) | (abs2 > TOL_V));
  end

  // Reference storage; contents are don't-care whenever the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ref_dpi_1, ref_dpi_2};
  end

  // FIFO pointers, statistics and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      occ            <= '0;
      cmp_count      <= '0;
      err_count      <= '0;
      max_err        <= '0;
      mismatch_pulse <= 1'b0;
      err_flag       <= 1'b0;
      ovf_flag       <= 1'b0;
      unf_flag       <= 1'b0;
    end else if (clear) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      occ            <= '0;
      cmp_count      <= '0;
      err_count      <= '0;
      max_err        <= '0;
      mismatch_pulse <= 1'b0;
      err_flag       <= 1'b0;
      ovf_flag       <= 1'b0;
      unf_flag       <= 1'b0;
    end else begin
      mismatch_pulse <= mis_ev;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OW'(wr_en) - OW'(rd_en);
      if (do_cmp) begin
        max_err <= max_next;
        if (cmp_count != CNT_MAX) cmp_count <= cmp_count + CNT_W'(1);
      end
      if (mis_ev) begin
        err_flag <= 1'b1;
        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
      end
      if (ovf_ev) ovf_flag <= 1'b1;
      if (unf_ev) unf_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gm_cubico_chk.sv
// tb/tb_gm_cubico_chk.sv - directed self-checking bench for gm_cubico_chk
module tb_gm_cubico_chk;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_enable;
  logic               ref_valid;
  logic signed [15:0] ref_dpi_1, ref_dpi_2;
  logic               dut_valid;
  logic signed [15:0] dut_y1, dut_y2;
  logic               clear;
  logic [15:0]        cmp_count, err_count;
  logic [16:0]        max_err;
  logic               mismatch_pulse, err_flag, ovf_flag, unf_flag;
  logic [2:0]         s_cmp, s_err;
  logic [16:0]        s_max;
  logic               s_pulse, s_ef, s_of, s_uf;

  int n_vec = 0;
  int n_bad = 0;

  gm_cubico_chk u_dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .ref_valid(ref_valid), .ref_dpi_1(ref_dpi_1), .ref_dpi_2(ref_dpi_2),
    .dut_valid(dut_valid), .dut_y1(dut_y1), .dut_y2(dut_y2), .clear(clear),
    .cmp_count(cmp_count), .err_count(err_count), .max_err(max_err),
    .mismatch_pulse(mismatch_pulse), .err_flag(err_flag),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  gm_cubico_chk #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .ref_valid(ref_valid), .ref_dpi_1(ref_dpi_1), .ref_dpi_2(ref_dpi_2),
    .dut_valid(dut_valid), .dut_y1(dut_y1), .dut_y2(dut_y2), .clear(clear),
    .cmp_count(s_cmp), .err_count(s_err), .max_err(s_max),
    .mismatch_pulse(s_pulse), .err_flag(s_ef),
    .ovf_flag(s_of), .unf_flag(s_uf)
  );

  initial forever #5 clk = ~clk;

  task automatic cyc(input logic rv, input logic signed [15:0] r1, input logic signed [15:0] r2,
                     input logic dv, input logic signed [15:0] d1, input logic signed [15:0] d2);
    ref_valid = rv; ref_dpi_1 = r1; ref_dpi_2 = r2;
    dut_valid = dv; dut_y1 = d1; dut_y2 = d2;
    @(posedge clk); #1;
    ref_valid = 1'b0; dut_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_enable = 1'b1; clear = 1'b0;
    ref_valid = 1'b0; dut_valid = 1'b0;
    ref_dpi_1 = '0; ref_dpi_2 = '0; dut_y1 = '0; dut_y2 = '0;
    #12;
    n_vec++; if (cmp_count !== 16'd0) begin n_bad++; $display("FAIL rst_cmp got %0d want 0", cmp_count); end
    n_vec++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL rst_err got %0d want 0", err_count); end
    n_vec++; if (max_err !== 17'd0) begin n_bad++; $display("FAIL rst_max got %0d want 0", max_err); end
    n_vec++; if ({mismatch_pulse, err_flag, ovf_flag, unf_flag} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_flags got %b want 0000", {mismatch_pulse, err_flag, ovf_flag, unf_flag}); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_matching();
    do_clear();
    for (int i = 0; i < 13; i++) begin
      cyc(i < 10, 16'(i + 1), -16'(i + 1), i >= 3, 16'(i - 2), -16'(i - 2));
      n_vec++; if (mismatch_pulse !== 1'b0) begin n_bad++; $display("FAIL match_pulse step %0d got %b want 0", i, mismatch_pulse); end
    end
    n_vec++; if (cmp_count !== 16'd10) begin n_bad++; $display("FAIL match_cmp got %0d want 10", cmp_count); end
    n_vec++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL match_err got %0d want 0", err_count); end
    n_vec++; if (max_err !== 17'd0) begin n_bad++; $display("FAIL match_max got %0d want 0", max_err); end
    n_vec++; if ({err_flag, ovf_flag, unf_flag} !== 3'b000) begin
      n_bad++; $display("FAIL match_flags got %b want 000", {err_flag, ovf_flag, unf_flag}); end
  endtask

  task automatic test_tolerance();
    do_clear();
    cyc(1'b1, 16'sd100, 16'sd0, 1'b1, 16'sd102, -16'sd2);
    n_vec++; if (mismatch_pulse !== 1'b0) begin n_bad++; $display("FAIL tol_edge_pulse got %b want 0", mismatch_pulse); end
    n_vec++; if (max_err !== 17'd2) begin n_bad++; $display("FAIL tol_edge_max got %0d want 2", max_err); end
    n_vec++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL tol_edge_err got %0d want 0", err_count); end
    cyc(1'b1, 16'sd100, 16'sd0, 1'b1, 16'sd103, 16'sd0);
    n_vec++; if (mismatch_pulse !== 1'b1) begin n_bad++; $display("FAIL tol_over_pulse got %b want 1", mismatch_pulse); end
    n_vec++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL tol_over_err got %0d want 1", err_count); end
    n_vec++; if (max_err !== 17'd3) begin n_bad++; $display("FAIL tol_over_max got %0d want 3", max_err); end
    n_vec++; if (err_flag !== 1'b1) begin n_bad++; $display("FAIL tol_over_flag got %b want 1", err_flag); end
    cyc(1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0);
    n_vec++; if (mismatch_pulse !== 1'b0) begin n_bad++; $display("FAIL tol_pulse_drop got %b want 0", mismatch_pulse); end
    n_vec++; if (err_flag !== 1'b1) begin n_bad++; $display("FAIL tol_flag_sticky got %b want 1", err_flag); end
  endtask

  task automatic test_extremes();
    do_clear();
    cyc(1'b1, -16'sd32768, 16'sd0, 1'b1, 16'sd32767, 16'sd0);
    n_vec++; if (max_err !== 17'd65535) begin n_bad++; $display("FAIL ext_pos_max got %0d want 65535", max_err); end
    n_vec++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL ext_pos_err got %0d want 1", err_count); end
    cyc(1'b1, 16'sd0, 16'sd32767, 1'b1, 16'sd0, -16'sd32768);
    n_vec++; if (max_err !== 17'd65535) begin n_bad++; $display("FAIL ext_neg_max got %0d want 65535", max_err); end
    n_vec++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL ext_neg_err got %0d want 2", err_count); end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 9; i++) cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd0, 16'sd3);
    n_vec++; if (s_err !== 3'd7) begin n_bad++; $display("FAIL sat_err got %0d want 7", s_err); end
    n_vec++; if (s_cmp !== 3'd7) begin n_bad++; $display("FAIL sat_cmp got %0d want 7", s_cmp); end
    n_vec++; if (s_pulse !== 1'b1) begin n_bad++; $display("FAIL sat_pulse got %b want 1", s_pulse); end
    n_vec++; if (err_count !== 16'd9) begin n_bad++; $display("FAIL sat_wide_err got %0d want 9", err_count); end
    n_vec++; if (max_err !== 17'd3) begin n_bad++; $display("FAIL sat_max got %0d want 3", max_err); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, 16'(k), 16'(100 + k), 1'b0, 16'sd0, 16'sd0);
      if (k == 8) begin
        n_vec++; if (ovf_flag !== 1'b0) begin n_bad++; $display("FAIL ovf_at8 got %b want 0", ovf_flag); end
      end
    end
    n_vec++; if (ovf_flag !== 1'b1) begin n_bad++; $display("FAIL ovf_at9 got %b want 1", ovf_flag); end
    for (int k = 1; k <= 8; k++) cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 16'(k), 16'(100 + k));
    n_vec++; if (cmp_count !== 16'd8) begin n_bad++; $display("FAIL ovf_cmp got %0d want 8", cmp_count); end
    n_vec++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL ovf_err got %0d want 0", err_count); end
    n_vec++; if (unf_flag !== 1'b0) begin n_bad++; $display("FAIL ovf_unf got %b want 0", unf_flag); end
    cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 16'sd9, 16'sd109);
    n_vec++; if (unf_flag !== 1'b1) begin n_bad++; $display("FAIL ovf_dropped_unf got %b want 1", unf_flag); end
    n_vec++; if (cmp_count !== 16'd8) begin n_bad++; $display("FAIL ovf_dropped_cmp got %0d want 8", cmp_count); end
  endtask

  task automatic test_underflow();
    do_clear();
    cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 16'sd5, 16'sd5);
    n_vec++; if (unf_flag !== 1'b1) begin n_bad++; $display("FAIL unf_flag got %b want 1", unf_flag); end
    n_vec++; if (cmp_count !== 16'd0) begin n_bad++; $display("FAIL unf_cmp got %0d want 0", cmp_count); end
    cyc(1'b1, 16'sd77, -16'sd77, 1'b1, 16'sd77, -16'sd77);
    n_vec++; if (cmp_count !== 16'd1) begin n_bad++; $display("FAIL byp_cmp got %0d want 1", cmp_count); end
    n_vec++; if (mismatch_pulse !== 1'b0) begin n_bad++; $display("FAIL byp_pulse got %b want 0", mismatch_pulse); end
    cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 16'sd77, -16'sd77);
    n_vec++; if (cmp_count !== 16'd1) begin n_bad++; $display("FAIL byp_empty_cmp got %0d want 1", cmp_count); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int k = 1; k <= 8; k++) cyc(1'b1, 16'(k), -16'(k), 1'b0, 16'sd0, 16'sd0);
    cyc(1'b1, 16'sd9, -16'sd9, 1'b1, 16'sd1, -16'sd1);
    n_vec++; if (ovf_flag !== 1'b0) begin n_bad++; $display("FAIL full_pp_ovf got %b want 0", ovf_flag); end
    for (int k = 2; k <= 9; k++) cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 16'(k), -16'(k));
    n_vec++; if (cmp_count !== 16'd9) begin n_bad++; $display("FAIL full_pp_cmp got %0d want 9", cmp_count); end
    n_vec++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL full_pp_err got %0d want 0", err_count); end
    n_vec++; if (unf_flag !== 1'b0) begin n_bad++; $display("FAIL full_pp_unf got %b want 0", unf_flag); end
    cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd5, 16'sd0);
    n_vec++; if (mismatch_pulse !== 1'b1) begin n_bad++; $display("FAIL b2b_first got %b want 1", mismatch_pulse); end
    cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd5, 16'sd0);
    n_vec++; if (mismatch_pulse !== 1'b1) begin n_bad++; $display("FAIL b2b_second got %b want 1", mismatch_pulse); end
    n_vec++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL b2b_err got %0d want 2", err_count); end
    clk_enable = 1'b0;
    cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd5, 16'sd0);
    n_vec++; if (mismatch_pulse !== 1'b0) begin n_bad++; $display("FAIL en_low_pulse got %b want 0", mismatch_pulse); end
    n_vec++; if (cmp_count !== 16'd11) begin n_bad++; $display("FAIL en_low_cmp got %0d want 11", cmp_count); end
    n_vec++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL en_low_err got %0d want 2", err_count); end
    clk_enable = 1'b1;
  endtask

  task automatic test_reset_clear_mid();
    do_clear();
    cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd10, 16'sd0);
    cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd10, 16'sd0);
    for (int k = 1; k <= 4; k++) cyc(1'b1, 16'(k), 16'(k), 1'b0, 16'sd0, 16'sd0);
    n_vec++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL mid_setup_err got %0d want 2", err_count); end
    reset = 1'b0;
    #1;
    n_vec++; if ({cmp_count, err_count} !== 32'd0) begin n_bad++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", cmp_count, err_count); end
    n_vec++; if ({max_err, mismatch_pulse, err_flag, ovf_flag, unf_flag} !== 21'd0) begin
      n_bad++; $display("FAIL mid_rst_misc got max %0d flags %b want 0", max_err, {mismatch_pulse, err_flag, ovf_flag, unf_flag}); end
    #2; reset = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 16'sd1, 16'sd1);
    n_vec++; if (unf_flag !== 1'b1) begin n_bad++; $display("FAIL mid_rst_unf got %b want 1", unf_flag); end
    n_vec++; if (cmp_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_cmp got %0d want 0", cmp_count); end

    do_clear();
    cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd10, 16'sd0);
    cyc(1'b1, 16'sd0, 16'sd0, 1'b1, 16'sd10, 16'sd0);
    for (int k = 1; k <= 4; k++) cyc(1'b1, 16'(k), 16'(k), 1'b0, 16'sd0, 16'sd0);
    clear = 1'b1;
    cyc(1'b1, 16'sd50, 16'sd50, 1'b1, 16'sd1, 16'sd1);
    clear = 1'b0;
    n_vec++; if ({cmp_count, err_count} !== 32'd0) begin n_bad++; $display("FAIL mid_clr_cnt got %0d/%0d want 0/0", cmp_count, err_count); end
    n_vec++; if ({max_err, mismatch_pulse, err_flag, ovf_flag, unf_flag} !== 21'd0) begin
      n_bad++; $display("FAIL mid_clr_misc got max %0d flags %b want 0", max_err, {mismatch_pulse, err_flag, ovf_flag, unf_flag}); end
    cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 16'sd50, 16'sd50);
    n_vec++; if (unf_flag !== 1'b1) begin n_bad++; $display("FAIL mid_clr_unf got %b want 1", unf_flag); end
    n_vec++; if (cmp_count !== 16'd0) begin n_bad++; $display("FAIL mid_clr_cmp got %0d want 0", cmp_count); end
  endtask

  initial begin
    test_reset();
    test_matching();
    test_tolerance();
    test_extremes();
    test_saturation();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gm_cubico_chk.md
# gm_cubico_chk

Streaming result checker for the cubic UFIR filter, placed directly downstream of the cubic UFIR golden-model source. It consumes the model's two 16-bit outputs (`dpi_1`, `dpi_2`) together with the filter DUT's two outputs. Reference samples are buffered in a FIFO to absorb DUT pipeline latency. Each DUT sample is compared against the oldest buffered reference sample with an absolute tolerance, and the block keeps saturating statistics and sticky fault flags that the bench reads at end of run.

## Interface
- `DATA_W`, 16, width of each signed sample channel
- `FIFO_DEPTH`, 8, number of reference sample pairs buffered (power of two, ≥2)
- `TOL`, 2, maximum absolute error in LSBs that still counts as a match
- `CNT_W`, 16, width of the statistics counters

- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low reset
- `clk_enable`  in  1  global enable; when low, no state changes
- `ref_valid`  in  1  reference sample pair present this cycle
- `ref_dpi_1`, `ref_dpi_2`  in  DATA_W each  reference outputs, signed
- `dut_valid`  in  1  DUT sample pair present this cycle
- `dut_y1`, `dut_y2`  in  DATA_W each  DUT outputs, signed
- `clear`  in  1  synchronous clear of FIFO, counters and flags
- `cmp_count`  out  CNT_W  number of comparisons performed
- `err_count`  out  CNT_W  number of mismatching comparisons
- `max_err`  out  DATA_W+1  largest absolute error seen on either channel, unsigned
- `mismatch_pulse`  out  1  one-cycle pulse per mismatching comparison
- `err_flag`  out  1  sticky; set on any mismatch
- `ovf_flag`  out  1  sticky; reference push dropped because the FIFO was full
- `unf_flag`  out  1  sticky; DUT sample arrived with no reference available

## Operation
- A push occurs when `clk_enable & ref_valid`. The pair `{ref_dpi_1, ref_dpi_2}` is written to the FIFO tail.
- A pop/compare occurs when `clk_enable & dut_valid`. The DUT pair is compared against the FIFO head, and the head is removed.
- Empty FIFO with simultaneous push and pop: bypass. The DUT pair is compared against the incoming reference pair, and the FIFO stays empty.
- Empty FIFO with pop and no push: no comparison is made, `unf_flag` is set, and `cmp_count` is unchanged.
- Full FIFO with push and no pop: the push is dropped and `ovf_flag` is set. Stored entries are unaffected.
- Full FIFO with push and pop together: both take effect, and occupancy stays at `FIFO_DEPTH`.
- Error arithmetic:
  - `diff = dut − ref`, sign-extended to DATA_W+1 bits.
  - `abs_err = |diff|`, unsigned in DATA_W+1 bits (max 2^DATA_W − 1); it never wraps.
- Mismatch condition: `abs_err1 > TOL` or `abs_err2 > TOL`.
- `max_err` updates to `max(max_err, abs_err1, abs_err2)` on every comparison.
- `cmp_count` and `err_count` saturate at all-ones and never wrap.
- `clear` (with `clk_enable` high or low) takes priority over push and pop in the same cycle. Any samples presented that cycle are discarded, and the block returns to its reset values.
- Reset values (asynchronous, while `reset` = 0) are all zero:
  - FIFO empty
  - all counters, `max_err` and every flag, including `mismatch_pulse`
- Reset asserted mid-operation discards the FIFO contents immediately.

## Timing
- All outputs are registered.
- A comparison at clock edge N is visible at edge N+1, i.e. one cycle of latency. This applies to `mismatch_pulse`, `err_flag`, `cmp_count`, `err_count` and `max_err`.
- `mismatch_pulse` is high for exactly one cycle per mismatch. Back-to-back mismatches keep it high on consecutive cycles.
- `ovf_flag` and `unf_flag` assert one cycle after the offending edge.
- When `clk_enable` is low, `mismatch_pulse` goes low at the next edge and all other state holds.
- The upstream model issues one pair every 5 enabled clocks. With `FIFO_DEPTH` = 8, DUT latencies up to 8 sample periods (40 clocks) are tolerated without overflow.

## Test plan
- **Matching stream:** 10 reference pairs (1..10, −1..−10); DUT replays the same values 3 samples late. Required: `cmp_count`=10, `err_count`=0, `max_err`=0, all flags 0.
- **Tolerance boundary:** ref (100, 0).
  - DUT (102, −2): no mismatch.
  - Next pair, DUT (103, 0): `mismatch_pulse` high one cycle, `err_count`=1, `max_err`=3, `err_flag`=1.
- **Extremes:** ref (−32768, 0), DUT (32767, 0). Required: `max_err`=65535, `err_count`+1, no wrap. Separately, preload `err_count` to 65535 and force a mismatch: it stays at 65535.
- **Overflow:** 9 pushes, no pops. Required: `ovf_flag`=1 after the 9th push. Then 8 DUT pairs equal to the first 8 references produce `cmp_count`=8, `err_count`=0.
- **Underflow/bypass:**
  - `dut_valid` with the FIFO empty and no push: `unf_flag`=1, `cmp_count` unchanged.
  - Push and pop together on an empty FIFO with equal values: `cmp_count`+1, no mismatch, FIFO stays empty.
- **Reset/clear mid-run:** with 4 entries buffered and `err_count`=2:
  - Drive `reset` low: all outputs read 0 immediately, and a following DUT sample sets `unf_flag`.
  - Repeat the setup and pulse `clear`: same result one edge later, and samples presented on the clear cycle are ignored.
